// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : RV32I instruction fetch: PC register, imem address, IF/ID register.
//            Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        squash_w;
  logic        capture_w;
  logic [1:0]  unused_redirect_lsbs_w;

  // Word alignment is forced, so the low target bits never reach the PC.
  assign unused_redirect_lsbs_w = redirect_pc_i[1:0];

  assign pc_plus4_w  = pc_q + 32'd4;
  assign squash_w    = flush_i | redirect_i;
  assign capture_w   = ~squash_w & ~stall_i;
  assign imem_addr_o = pc_q;

  always_comb begin
    pc_d = pc_plus4_w;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    if (squash_w) begin
      instr_d  = NOP_INSTR;
      id_pc_d  = 32'd0;
      id_pc4_d = 32'd0;
      valid_d  = 1'b0;
    end else if (capture_w) begin
      instr_d  = imem_instr_i;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4_w;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      id_pc_q  <= 32'd0;
      id_pc4_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
    end
  end

  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign if_id_valid_o = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A stall only counts when it actually holds the pipe, not when squashed.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (capture_w) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
    if (stall_i && !squash_w) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed self-checking bench for if_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_valid_o (if_id_valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: four program words, everything else is addr ^ A5A5_0000.
  always_comb begin
    case (imem_addr_o)
      32'h0000_0000: imem_instr_i = 32'h0032_A383;
      32'h0000_0004: imem_instr_i = 32'h0033_8433;
      32'h0000_0008: imem_instr_i = 32'h0073_6133;
      32'h0000_000C: imem_instr_i = 32'h4023_81B3;
      default:       imem_instr_i = imem_addr_o ^ 32'hA5A5_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic valid, input logic [31:0] addr);
    check({tag, ".instr"}, if_id_instr_o, instr);
    check({tag, ".pc"},    if_id_pc_o,    pc);
    check({tag, ".pc4"},   if_id_pc4_o,   pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
    check({tag, ".addr"},  imem_addr_o,   addr);
  endtask

  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  initial begin
    rst_i         = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd6;
    exp_stall = 32'd3;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif

    // Reset held across edges
    step();
    step();
    check_ifid("rst", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'd0);
    check("rst.fcnt", fetch_cnt_o, 32'd0);
    check("rst.scnt", stall_cnt_o, 32'd0);

    // Release and free-run
    rst_i = 1'b1;
    step();
    check_ifid("run0", 32'h0032_A383, 32'd0, 32'd4, 1'b1, 32'd4);
    step();
    check_ifid("run4", 32'h0033_8433, 32'd4, 32'd8, 1'b1, 32'd8);

    // Stall two cycles with pc_q = 8
    stall_i = 1'b1;
    step();
    check_ifid("stall1", 32'h0033_8433, 32'd4, 32'd8, 1'b1, 32'd8);
    step();
    check_ifid("stall2", 32'h0033_8433, 32'd4, 32'd8, 1'b1, 32'd8);
    stall_i = 1'b0;
    step();
    check_ifid("run8", 32'h0073_6133, 32'd8, 32'd12, 1'b1, 32'd12);
    step();
    check_ifid("run12", 32'h4023_81B3, 32'd12, 32'd16, 1'b1, 32'd16);

    // Redirect with simultaneous stall; low target bits dropped
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0043;
    stall_i       = 1'b1;
    step();
    check_ifid("redir", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'h40);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    step();
    check_ifid("tgt", 32'hA5A5_0040, 32'h40, 32'h44, 1'b1, 32'h44);

    // Flush wins over stall; PC held by stall
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    check_ifid("flush", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'h44);
    flush_i = 1'b0;
    step();
    check_ifid("flstall", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'h44);
    stall_i = 1'b0;

    // PC wrap at top of address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    check_ifid("wrapredir", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC);
    redirect_i = 1'b0;
    step();
    check_ifid("wrap", 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'd0);

    // Counters, then asynchronous reset between clock edges
    check("cnt.fetch", fetch_cnt_o, exp_fetch);
    check("cnt.stall", stall_cnt_o, exp_stall);
    #2;
    rst_i = 1'b0;
    #1;
    check_ifid("arst", 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'd0);
    check("arst.fcnt", fetch_cnt_o, 32'd0);
    check("arst.scnt", stall_cnt_o, 32'd0);

    step();
    rst_i = 1'b1;
    step();
    check_ifid("rerun0", 32'h0032_A383, 32'd0, 32'd4, 1'b1, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
